// File: rtl/mem_read_seq_m0.sv
// Read-address sequencer for matrix m0.
// On start, walks pass -> row -> column over the m0 bank slice and drives
// the banked-BRAM read stage with registered row/column/rd_en. It then waits
// N+1 cycles for the read pipeline to drain and pulses done.
//
// Handshake: rd_en is a one-cycle issue strobe. Each cycle with rd_en=1
// carries exactly one (row, column) coordinate. While stall is high, no new
// coordinate is issued; the last presented coordinate is held with rd_en=0.
module mem_read_seq_m0 #(
   parameter int D_W    = 8,
   parameter int N      = 3,
   parameter int M      = 6,
   parameter int PASSES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stall,
   output logic [$clog2(M/N)-1:0]   row,
   output logic [$clog2(M)-1:0]     column,
   output logic                     rd_en,
   output logic                     busy,
   output logic                     done
);

   localparam int R    = M / N;
   localparam int RW   = $clog2(R);
   localparam int CW   = $clog2(M);
   localparam int PW   = $clog2(PASSES + 1);
   localparam int DCW  = $clog2(N + 2);

   localparam logic [RW-1:0]  ROW_LAST   = RW'(R - 1);
   localparam logic [CW-1:0]  COL_LAST   = CW'(M - 1);
   localparam logic [PW-1:0]  PASS_END   = PW'(PASSES);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(N);

   // Elaboration-time parameter sanity checks.
   if (D_W < 1 || N < 1 || PASSES < 1 || (M % N) != 0 || (M / N) < 2) begin : g_bad_params
      $error("mem_read_seq_m0: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    pass_q, pass_d;
   logic [RW-1:0]    row_cnt_q, row_cnt_d;
   logic [CW-1:0]    col_cnt_q, col_cnt_d;
   logic [DCW-1:0]   drain_q, drain_d;
   logic [RW-1:0]    row_q, row_d;
   logic [CW-1:0]    col_q, col_d;
   logic             rd_en_q, rd_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Coordinate after the one held in the issue counters (column inner, row middle, pass outer).
   logic [PW-1:0]    nxt_pass;
   logic [RW-1:0]    nxt_row;
   logic [CW-1:0]    nxt_col;

   // Advance the issue counters by one coordinate, wrapping by explicit compare.
   always_comb begin
      nxt_pass = pass_q;
      nxt_row  = row_cnt_q;
      nxt_col  = col_cnt_q + CW'(1);
      if (col_cnt_q == COL_LAST) begin
         nxt_col = '0;
         if (row_cnt_q == ROW_LAST) begin
            nxt_row  = '0;
            nxt_pass = pass_q + PW'(1);
         end else begin
            nxt_row = row_cnt_q + RW'(1);
         end
      end
   end

   // Next-state and next-output logic for the sequencer FSM.
   always_comb begin
      state_d   = state_q;
      pass_d    = pass_q;
      row_cnt_d = row_cnt_q;
      col_cnt_d = col_cnt_q;
      drain_d   = drain_q;
      row_d     = row_q;
      col_d     = col_q;
      rd_en_d   = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d   = RUN;
               busy_d    = 1'b1;
               pass_d    = '0;
               row_cnt_d = '0;
               col_cnt_d = '0;
               row_d     = '0;
               col_d     = '0;
               // First coordinate goes out on the accepting edge unless stalled.
               if (!stall) begin
                  rd_en_d   = 1'b1;
                  col_cnt_d = CW'(1);
               end
            end
         end

         RUN: begin
            // pass counter reaching PASSES means the final coordinate is already out.
            if (pass_q == PASS_END) begin
               state_d = DRAIN;
               row_d   = '0;
               col_d   = '0;
               drain_d = '0;
            end else if (!stall) begin
               rd_en_d   = 1'b1;
               row_d     = row_cnt_q;
               col_d     = col_cnt_q;
               pass_d    = nxt_pass;
               row_cnt_d = nxt_row;
               col_cnt_d = nxt_col;
            end
         end

         DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + DCW'(1);
            end
         end

         DONE: begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            pass_d    = '0;
            row_cnt_d = '0;
            col_cnt_d = '0;
            drain_d   = '0;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; synchronous reset aborts any sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pass_q    <= '0;
         row_cnt_q <= '0;
         col_cnt_q <= '0;
         drain_q   <= '0;
         row_q     <= '0;
         col_q     <= '0;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pass_q    <= pass_d;
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
         drain_q   <= drain_d;
         row_q     <= row_d;
         col_q     <= col_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign row    = row_q;
   assign column = col_q;
   assign rd_en  = rd_en_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_mem_read_seq_m0.sv
// Bench for mem_read_seq_m0: default instance (N=3, M=6, PASSES=2) and a
// small instance (N=2, M=4, PASSES=1) sharing clock and reset.
module tb_mem_read_seq_m0;

   logic clk;
   logic rst;
   logic start;
   logic stall;
   logic sel;

   logic       start_a, stall_a, start_b, stall_b;
   logic [0:0] a_row;
   logic [2:0] a_col;
   logic       a_rd_en, a_busy, a_done;
   logic [0:0] b_row;
   logic [1:0] b_col;
   logic       b_rd_en, b_busy, b_done;

   int o_row, o_col;
   logic o_rd_en, o_busy, o_done;

   int n_cmp;
   int n_fail;

   logic [15:0] exp_q[$];

   typedef struct {
      bit start;
      bit stall;
      bit rd_en;
      int row;
      int col;
      bit busy;
      bit done;
   } vec_t;

   vec_t tbl[8];

   // Clock and input steering
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign start_a = start & ~sel;
   assign stall_a = stall & ~sel;
   assign start_b = start & sel;
   assign stall_b = stall & sel;

   assign o_row   = sel ? int'(b_row) : int'(a_row);
   assign o_col   = sel ? int'(b_col) : int'(a_col);
   assign o_rd_en = sel ? b_rd_en : a_rd_en;
   assign o_busy  = sel ? b_busy  : a_busy;
   assign o_done  = sel ? b_done  : a_done;

   mem_read_seq_m0 #(.D_W(8), .N(3), .M(6), .PASSES(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .stall(stall_a),
      .row(a_row), .column(a_col), .rd_en(a_rd_en), .busy(a_busy), .done(a_done)
   );

   mem_read_seq_m0 #(.D_W(8), .N(2), .M(4), .PASSES(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .stall(stall_b),
      .row(b_row), .column(b_col), .rd_en(b_rd_en), .busy(b_busy), .done(b_done)
   );

   // Driver helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard fill: pass outer, row middle, column inner.
   task automatic fill_exp(input int passes, input int rows, input int m);
      exp_q.delete();
      for (int p = 0; p < passes; p++)
         for (int r = 0; r < rows; r++)
            for (int c = 0; c < m; c++)
               exp_q.push_back(16'((r << 8) | c));
   endtask

   task automatic chk_issue(input string name);
      if (exp_q.size() == 0) chk({name, " extra issue"}, 1, 0);
      else chk({name, " coord"}, (o_row << 8) | o_col, int'(exp_q.pop_front()));
   endtask

   // Start with stall low; first coordinate is visible right after the edge.
   task automatic launch(input string name);
      start = 1'b1;
      stall = 1'b0;
      tick();
      start = 1'b0;
      chk({name, " busy at start"}, int'(o_busy), 1);
      chk({name, " rd_en at start"}, int'(o_rd_en), 1);
      chk_issue(name);
   endtask

   // Follow a running sequence to done and check counts and drain latency.
   task automatic monitor(input string name, input int total, input int drain,
                          input int issued0, input int busy0, input int extra_busy,
                          input bit mid_stall, input bit poke_start);
      int issued, busy_n, gap, stall_left, stalls;
      bit got_done, stall_used, stalled;
      issued = issued0; busy_n = busy0; gap = 0; stall_left = 0; stalls = 0;
      got_done = 1'b0; stall_used = 1'b0;
      for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
         stalled = (stall_left > 0);
         stall = stalled;
         start = poke_start && (issued == 10);
         tick();
         start = 1'b0;
         stall = 1'b0;
         if (stalled) begin
            stall_left--;
            stalls++;
            chk({name, " stall rd_en"}, int'(o_rd_en), 0);
            chk({name, " stall row held"}, o_row, 0);
            chk({name, " stall col held"}, o_col, 2);
         end
         if (o_busy) busy_n++;
         if (o_rd_en) begin
            chk_issue(name);
            issued++;
            gap = 0;
            if (mid_stall && !stall_used && issued == 3) begin
               stall_left = 3;
               stall_used = 1'b1;
            end
         end else begin
            gap++;
         end
         if (o_done) got_done = 1'b1;
      end
      chk({name, " done seen"}, int'(got_done), 1);
      if (got_done) begin
         chk({name, " drain cycles"}, gap - 1, drain + 1);
         chk({name, " issue count"}, issued, total);
         chk({name, " busy cycles"}, busy_n, total + drain + 2 + extra_busy + stalls);
         chk({name, " leftover expected"}, exp_q.size(), 0);
         start = poke_start;
         tick();
         start = 1'b0;
         chk({name, " done one cycle"}, int'(o_done), 0);
         chk({name, " busy after done"}, int'(o_busy), 0);
         chk({name, " rd_en after done"}, int'(o_rd_en), 0);
         for (int k = 0; k < 4; k++) begin
            tick();
            chk({name, " idle busy"}, int'(o_busy), 0);
            chk({name, " idle done"}, int'(o_done), 0);
         end
      end
   endtask

   // Main sequence and final report
   initial begin
      int issued;
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; start = 1'b0; stall = 1'b0; sel = 1'b0;

      // start=1 stalled for 5 edges, then three clean issues.
      tbl[0] = '{1, 1, 0, 0, 0, 1, 0};
      tbl[1] = '{0, 1, 0, 0, 0, 1, 0};
      tbl[2] = '{0, 1, 0, 0, 0, 1, 0};
      tbl[3] = '{0, 1, 0, 0, 0, 1, 0};
      tbl[4] = '{0, 1, 0, 0, 0, 1, 0};
      tbl[5] = '{0, 0, 1, 0, 0, 1, 0};
      tbl[6] = '{0, 0, 1, 0, 1, 1, 0};
      tbl[7] = '{0, 0, 1, 0, 2, 1, 0};

      tick();
      tick();
      rst = 1'b0;
      chk("reset a rd_en", int'(a_rd_en), 0);
      chk("reset a busy", int'(a_busy), 0);
      chk("reset a done", int'(a_done), 0);
      chk("reset a row", int'(a_row), 0);
      chk("reset a col", int'(a_col), 0);
      chk("reset b rd_en", int'(b_rd_en), 0);
      chk("reset b busy", int'(b_busy), 0);

      // Simultaneous start and rst: reset wins.
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("start+rst busy", int'(a_busy), 0);
      tick();
      chk("start+rst stays idle busy", int'(a_busy), 0);
      chk("start+rst stays idle rd_en", int'(a_rd_en), 0);

      // Plain sequence.
      fill_exp(2, 2, 6);
      launch("basic");
      monitor("basic", 24, 3, 1, 1, 0, 1'b0, 1'b0);

      // Three stall cycles while (0,2) is presented.
      fill_exp(2, 2, 6);
      launch("midstall");
      monitor("midstall", 24, 3, 1, 1, 0, 1'b1, 1'b0);

      // start poked during RUN and in the DONE cycle.
      fill_exp(2, 2, 6);
      launch("restart");
      monitor("restart", 24, 3, 1, 1, 0, 1'b0, 1'b1);

      // Start under a 5-cycle stall, table-driven.
      fill_exp(2, 2, 6);
      for (int i = 0; i < 8; i++) begin
         start = tbl[i].start;
         stall = tbl[i].stall;
         tick();
         start = 1'b0;
         stall = 1'b0;
         chk($sformatf("tbl[%0d] rd_en", i), int'(o_rd_en), int'(tbl[i].rd_en));
         chk($sformatf("tbl[%0d] row", i), o_row, tbl[i].row);
         chk($sformatf("tbl[%0d] col", i), o_col, tbl[i].col);
         chk($sformatf("tbl[%0d] busy", i), int'(o_busy), int'(tbl[i].busy));
         chk($sformatf("tbl[%0d] done", i), int'(o_done), int'(tbl[i].done));
      end
      for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
      monitor("startstall", 24, 3, 3, 8, 5, 1'b0, 1'b0);

      // Reset at pass 1, row 1, column 4 (23rd issue).
      fill_exp(2, 2, 6);
      launch("abort");
      issued = 1;
      for (int cyc = 0; cyc < 100 && issued < 23; cyc++) begin
         tick();
         if (o_rd_en) begin
            chk_issue("abort");
            issued++;
         end
      end
      chk("abort reached 23rd issue", issued, 23);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort rd_en", int'(o_rd_en), 0);
      chk("abort row", o_row, 0);
      chk("abort col", o_col, 0);
      chk("abort busy", int'(o_busy), 0);
      chk("abort done", int'(o_done), 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("abort no done", int'(o_done), 0);
         chk("abort stays idle", int'(o_busy), 0);
      end
      fill_exp(2, 2, 6);
      launch("after abort");
      monitor("after abort", 24, 3, 1, 1, 0, 1'b0, 1'b0);

      // Small instance: N=2, M=4, PASSES=1.
      sel = 1'b1;
      tick();
      fill_exp(1, 2, 4);
      launch("small");
      monitor("small", 8, 2, 1, 1, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
